// File: rtl/al_bus_arbiter.sv
// Two-master arbiter for the AL register bus: round-robin write grant with bounded hold,
// round-robin read-address arbitration, and an ID FIFO that routes read data back in order.
module al_bus_arbiter #(
  parameter int AL_BUS_WIDTH = 12,
  parameter int MAX_HOLD     = 16,
  parameter int OUTST_LOG2   = 2
) (
  input  logic                    clk,
  input  logic                    rst_n,
  input  logic [AL_BUS_WIDTH-3:0] s0_al_waddr,
  input  logic [31:0]             s0_al_wdata,
  input  logic                    s0_al_wvalid,
  output logic                    s0_al_wready,
  input  logic [AL_BUS_WIDTH-3:0] s0_al_araddr,
  input  logic                    s0_al_arvalid,
  output logic                    s0_al_arready,
  output logic [31:0]             s0_al_rdata,
  output logic                    s0_al_rvalid,
  input  logic                    s0_al_rready,
  input  logic [AL_BUS_WIDTH-3:0] s1_al_waddr,
  input  logic [31:0]             s1_al_wdata,
  input  logic                    s1_al_wvalid,
  output logic                    s1_al_wready,
  input  logic [AL_BUS_WIDTH-3:0] s1_al_araddr,
  input  logic                    s1_al_arvalid,
  output logic                    s1_al_arready,
  output logic [31:0]             s1_al_rdata,
  output logic                    s1_al_rvalid,
  input  logic                    s1_al_rready,
  output logic [AL_BUS_WIDTH-3:0] m_al_waddr,
  output logic [31:0]             m_al_wdata,
  output logic                    m_al_wvalid,
  input  logic                    m_al_wready,
  output logic [AL_BUS_WIDTH-3:0] m_al_araddr,
  output logic                    m_al_arvalid,
  input  logic                    m_al_arready,
  input  logic [31:0]             m_al_rdata,
  input  logic                    m_al_rvalid,
  output logic                    m_al_rready,
  output logic                    rd_orphan,
  output logic [1:0]              o_dbg_wstate
);

  // Handshake rule on every channel: a beat transfers on a clock edge where valid and
  // ready are both high; a master holds valid and its payload stable until that edge.

  localparam int DEPTH = 1 << OUTST_LOG2;
  localparam logic [7:0]            HOLD_MAX = 8'(MAX_HOLD);
  localparam logic [OUTST_LOG2:0]   CNT_ONE  = (OUTST_LOG2+1)'(1);
  localparam logic [OUTST_LOG2:0]   CNT_FULL = (OUTST_LOG2+1)'(DEPTH);
  localparam logic [OUTST_LOG2-1:0] PTR_ONE  = (OUTST_LOG2)'(1);

  typedef enum logic [1:0] {
    W_IDLE = 2'd0,
    W_S0   = 2'd1,
    W_S1   = 2'd2
  } wstate_t;

  wstate_t r_wstate;
  wstate_t w_wnext;
  wstate_t w_oth_state;
  logic    r_wlast;
  logic    w_wlast_next;
  logic [7:0] r_hold_cnt;
  logic [7:0] w_hold_next;
  logic [7:0] w_hold_inc;
  logic    w_cur_v;
  logic    w_oth_v;
  logic    w_cur_id;

  assign w_hold_inc   = r_hold_cnt + 8'd1;
  assign o_dbg_wstate = r_wstate;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_wstate   <= W_IDLE;
      r_wlast    <= 1'b1;
      r_hold_cnt <= 8'd0;
    end else begin
      r_wstate   <= w_wnext;
      r_wlast    <= w_wlast_next;
      r_hold_cnt <= w_hold_next;
    end
  end

  always_comb begin
    w_wnext      = r_wstate;
    w_wlast_next = r_wlast;
    w_hold_next  = r_hold_cnt;
    w_cur_v      = 1'b0;
    w_oth_v      = 1'b0;
    w_oth_state  = W_IDLE;
    w_cur_id     = 1'b0;
    m_al_wvalid  = 1'b0;
    m_al_waddr   = s0_al_waddr;
    m_al_wdata   = s0_al_wdata;
    s0_al_wready = 1'b0;
    s1_al_wready = 1'b0;
    case (r_wstate)
      W_S0: begin
        w_cur_v      = s0_al_wvalid;
        w_oth_v      = s1_al_wvalid;
        w_oth_state  = W_S1;
        w_cur_id     = 1'b0;
        m_al_wvalid  = s0_al_wvalid;
        s0_al_wready = m_al_wready;
      end
      W_S1: begin
        w_cur_v      = s1_al_wvalid;
        w_oth_v      = s0_al_wvalid;
        w_oth_state  = W_S0;
        w_cur_id     = 1'b1;
        m_al_wvalid  = s1_al_wvalid;
        m_al_waddr   = s1_al_waddr;
        m_al_wdata   = s1_al_wdata;
        s1_al_wready = m_al_wready;
      end
      default: ;
    endcase

    if (r_wstate == W_IDLE) begin
      if (s0_al_wvalid && s1_al_wvalid) w_wnext = r_wlast ? W_S0 : W_S1;
      else if (s0_al_wvalid)            w_wnext = W_S0;
      else if (s1_al_wvalid)            w_wnext = W_S1;
    end else if (r_wstate != W_S0 && r_wstate != W_S1) begin
      w_wnext = W_IDLE;
    end else if (!w_cur_v) begin
      w_wnext      = w_oth_v ? w_oth_state : W_IDLE;
      w_wlast_next = w_cur_id;
      w_hold_next  = 8'd0;
    end else if (m_al_wready) begin
      // Hold limit reached: yield only if the other master wants the bus.
      if (w_hold_inc == HOLD_MAX) begin
        w_hold_next = 8'd0;
        if (w_oth_v) begin
          w_wnext      = w_oth_state;
          w_wlast_next = w_cur_id;
        end
      end else begin
        w_hold_next = w_hold_inc;
      end
    end
  end

  logic                  r_fifo [DEPTH];
  logic [OUTST_LOG2-1:0] r_wptr;
  logic [OUTST_LOG2-1:0] r_rptr;
  logic [OUTST_LOG2:0]   r_count;
  logic                  r_arlast;
  logic                  r_ar_lock;
  logic                  r_ar_sel_q;
  logic                  r_orphan;
  logic                  w_fifo_empty;
  logic                  w_fifo_full;
  logic                  w_head;
  logic                  w_head_rready;
  logic                  w_pop;
  logic                  w_push;
  logic                  w_ar_pick;
  logic                  w_ar_sel;

  assign w_fifo_empty  = (r_count == '0);
  assign w_head        = r_fifo[r_rptr];
  assign w_head_rready = w_head ? s1_al_rready : s0_al_rready;
  assign w_pop         = m_al_rvalid & ~w_fifo_empty & w_head_rready;
  // A pop in the same cycle frees a slot, so a full FIFO can still take a new read.
  assign w_fifo_full   = (r_count == CNT_FULL) & ~w_pop;

  assign w_ar_pick     = (s0_al_arvalid & s1_al_arvalid) ? ~r_arlast : s1_al_arvalid;
  assign w_ar_sel      = r_ar_lock ? r_ar_sel_q : w_ar_pick;
  assign m_al_arvalid  = (s0_al_arvalid | s1_al_arvalid) & ~w_fifo_full;
  assign m_al_araddr   = w_ar_sel ? s1_al_araddr : s0_al_araddr;
  assign s0_al_arready = m_al_arvalid & m_al_arready & ~w_ar_sel;
  assign s1_al_arready = m_al_arvalid & m_al_arready & w_ar_sel;
  assign w_push        = m_al_arvalid & m_al_arready;

  assign s0_al_rdata   = m_al_rdata;
  assign s1_al_rdata   = m_al_rdata;
  assign s0_al_rvalid  = m_al_rvalid & ~w_fifo_empty & ~w_head;
  assign s1_al_rvalid  = m_al_rvalid & ~w_fifo_empty & w_head;
  assign m_al_rready   = w_fifo_empty | w_head_rready;
  assign rd_orphan     = r_orphan;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int i = 0; i < DEPTH; i++) r_fifo[i] <= 1'b0;
      r_wptr     <= '0;
      r_rptr     <= '0;
      r_count    <= '0;
      r_arlast   <= 1'b1;
      r_ar_lock  <= 1'b0;
      r_ar_sel_q <= 1'b0;
      r_orphan   <= 1'b0;
    end else begin
      r_ar_lock  <= m_al_arvalid & ~m_al_arready;
      r_ar_sel_q <= w_ar_sel;
      r_orphan   <= m_al_rvalid & w_fifo_empty;
      if (w_push) begin
        r_fifo[r_wptr] <= w_ar_sel;
        r_wptr         <= r_wptr + PTR_ONE;
        r_arlast       <= w_ar_sel;
      end
      if (w_pop) r_rptr <= r_rptr + PTR_ONE;
      if (w_push && !w_pop)      r_count <= r_count + CNT_ONE;
      else if (!w_push && w_pop) r_count <= r_count - CNT_ONE;
    end
  end

endmodule

// File: tb/tb_al_bus_arbiter.sv
// Bench for al_bus_arbiter: directed scenarios plus randomized write and read traffic
// checked against a transaction-level model of grant ownership and outstanding reads.
module tb_al_bus_arbiter;
  localparam int AW         = 10;
  localparam int MAX_HOLD   = 4;
  localparam int OUTST_LOG2 = 2;
  localparam int DEPTH      = 4;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  logic [AW-1:0] s0_al_waddr, s1_al_waddr, s0_al_araddr, s1_al_araddr;
  logic [31:0]   s0_al_wdata, s1_al_wdata;
  logic s0_al_wvalid, s1_al_wvalid, s0_al_wready, s1_al_wready;
  logic s0_al_arvalid, s1_al_arvalid, s0_al_arready, s1_al_arready;
  logic [31:0]   s0_al_rdata, s1_al_rdata;
  logic s0_al_rvalid, s1_al_rvalid, s0_al_rready, s1_al_rready;
  logic [AW-1:0] m_al_waddr, m_al_araddr;
  logic [31:0]   m_al_wdata, m_al_rdata;
  logic m_al_wvalid, m_al_wready, m_al_arvalid, m_al_arready;
  logic m_al_rvalid, m_al_rready, rd_orphan;
  logic [1:0] dbg_wstate;

  int n_vec = 0;
  int n_err = 0;

  always #5 clk = ~clk;

  al_bus_arbiter #(.AL_BUS_WIDTH(AW+2), .MAX_HOLD(MAX_HOLD), .OUTST_LOG2(OUTST_LOG2)) dut (
    .clk(clk), .rst_n(rst_n),
    .s0_al_waddr(s0_al_waddr), .s0_al_wdata(s0_al_wdata), .s0_al_wvalid(s0_al_wvalid),
    .s0_al_wready(s0_al_wready), .s0_al_araddr(s0_al_araddr), .s0_al_arvalid(s0_al_arvalid),
    .s0_al_arready(s0_al_arready), .s0_al_rdata(s0_al_rdata), .s0_al_rvalid(s0_al_rvalid),
    .s0_al_rready(s0_al_rready),
    .s1_al_waddr(s1_al_waddr), .s1_al_wdata(s1_al_wdata), .s1_al_wvalid(s1_al_wvalid),
    .s1_al_wready(s1_al_wready), .s1_al_araddr(s1_al_araddr), .s1_al_arvalid(s1_al_arvalid),
    .s1_al_arready(s1_al_arready), .s1_al_rdata(s1_al_rdata), .s1_al_rvalid(s1_al_rvalid),
    .s1_al_rready(s1_al_rready),
    .m_al_waddr(m_al_waddr), .m_al_wdata(m_al_wdata), .m_al_wvalid(m_al_wvalid),
    .m_al_wready(m_al_wready), .m_al_araddr(m_al_araddr), .m_al_arvalid(m_al_arvalid),
    .m_al_arready(m_al_arready), .m_al_rdata(m_al_rdata), .m_al_rvalid(m_al_rvalid),
    .m_al_rready(m_al_rready), .rd_orphan(rd_orphan), .o_dbg_wstate(dbg_wstate)
  );

  task automatic clear_inputs();
    s0_al_waddr = '0; s0_al_wdata = '0; s0_al_wvalid = 1'b0;
    s1_al_waddr = '0; s1_al_wdata = '0; s1_al_wvalid = 1'b0;
    s0_al_araddr = '0; s0_al_arvalid = 1'b0; s0_al_rready = 1'b0;
    s1_al_araddr = '0; s1_al_arvalid = 1'b0; s1_al_rready = 1'b0;
    m_al_wready = 1'b0; m_al_arready = 1'b0; m_al_rdata = '0; m_al_rvalid = 1'b0;
  endtask

  task automatic apply_reset();
    @(negedge clk);
    clear_inputs();
    rst_n = 1'b0;
    @(negedge clk);
    @(negedge clk);
    rst_n = 1'b1;
  endtask

  task automatic test_reset();
    logic [9:0] obs;
    @(negedge clk);
    clear_inputs();
    rst_n = 1'b0;
    #1;
    obs = {m_al_wvalid, s0_al_wready, s1_al_wready, m_al_arvalid, s0_al_arready,
           s1_al_arready, s0_al_rvalid, s1_al_rvalid, m_al_rready, rd_orphan};
    n_vec++;
    if (obs !== 10'b0000000010) begin
      n_err++; $display("FAIL reset_outputs: got %b expected 0000000010", obs);
    end
    // Inputs active while reset is held: nothing may be granted or flagged.
    s0_al_wvalid = 1'b1; m_al_wready = 1'b1; m_al_arready = 1'b1; m_al_rvalid = 1'b1;
    @(negedge clk); #1;
    obs = {m_al_wvalid, s0_al_wready, s1_al_wready, m_al_arvalid, s0_al_arready,
           s1_al_arready, s0_al_rvalid, s1_al_rvalid, m_al_rready, rd_orphan};
    n_vec++;
    if (obs !== 10'b0000000010) begin
      n_err++; $display("FAIL reset_held: got %b expected 0000000010", obs);
    end
    clear_inputs();
    rst_n = 1'b1;
  endtask

  task automatic test_single_write();
    logic [31:0] d [3];
    apply_reset();
    for (int i = 0; i < 3; i++) d[i] = $urandom;
    m_al_wready = 1'b1;
    @(negedge clk);
    s0_al_wvalid = 1'b1; s0_al_waddr = 10'h010; s0_al_wdata = d[0];
    #1;
    n_vec++;
    if (m_al_wvalid !== 1'b0) begin
      n_err++; $display("FAIL single_grant_latency: m_wvalid=%b expected 0", m_al_wvalid);
    end
    for (int i = 0; i < 3; i++) begin
      @(negedge clk);
      s0_al_waddr = 10'(16 + i); s0_al_wdata = d[i];
      #1;
      n_vec++;
      if ({m_al_wvalid, s0_al_wready, s1_al_wready} !== 3'b110) begin
        n_err++; $display("FAIL single_beat%0d_hs: got %b expected 110", i,
                          {m_al_wvalid, s0_al_wready, s1_al_wready});
      end
      n_vec++;
      if ({m_al_waddr, m_al_wdata} !== {10'(16 + i), d[i]}) begin
        n_err++; $display("FAIL single_beat%0d_payload: got %h/%h expected %h/%h", i,
                          m_al_waddr, m_al_wdata, 10'(16 + i), d[i]);
      end
    end
    @(negedge clk);
    s0_al_wvalid = 1'b0;
    #1;
    n_vec++;
    if (m_al_wvalid !== 1'b0) begin
      n_err++; $display("FAIL single_release: m_wvalid=%b expected 0", m_al_wvalid);
    end
  endtask

  task automatic test_write_contention();
    int b [2];
    int owner;
    logic [AW-1:0] ea;
    apply_reset();
    b[0] = 0; b[1] = 0;
    m_al_wready = 1'b1;
    @(negedge clk);
    s0_al_wvalid = 1'b1; s1_al_wvalid = 1'b1;
    #1;
    n_vec++;
    if (m_al_wvalid !== 1'b0) begin
      n_err++; $display("FAIL contend_idle: m_wvalid=%b expected 0", m_al_wvalid);
    end
    // After reset master 0 wins first, then ownership flips every MAX_HOLD beats.
    for (int k = 0; k < 5 * MAX_HOLD; k++) begin
      @(negedge clk);
      s0_al_waddr = 10'(160 + b[0]); s1_al_waddr = 10'(176 + b[1]);
      s0_al_wdata = 32'(k); s1_al_wdata = 32'(1000 + k);
      #1;
      owner = (k / MAX_HOLD) % 2;
      ea = (owner == 0) ? 10'(160 + b[0]) : 10'(176 + b[1]);
      n_vec++;
      if ({m_al_wvalid, s0_al_wready, s1_al_wready} !== {1'b1, owner == 0, owner == 1}) begin
        n_err++; $display("FAIL contend_k%0d_grant: got %b expected owner s%0d", k,
                          {m_al_wvalid, s0_al_wready, s1_al_wready}, owner);
      end
      n_vec++;
      if (m_al_waddr !== ea) begin
        n_err++; $display("FAIL contend_k%0d_addr: got %h expected %h", k, m_al_waddr, ea);
      end
      b[owner]++;
    end
    @(negedge clk);
    s0_al_wvalid = 1'b0; s1_al_wvalid = 1'b0;
  endtask

  task automatic test_random_write();
    int owner, run, last, oth;
    logic v [2];
    logic wr, exp_wv;
    logic [AW-1:0] ea;
    logic [31:0] ed;
    apply_reset();
    owner = -1; run = 0; last = 1;
    for (int k = 0; k < 300; k++) begin
      @(negedge clk);
      v[0] = ($urandom_range(0, 3) != 0);
      v[1] = ($urandom_range(0, 3) != 0);
      wr = ($urandom_range(0, 3) != 0);
      s0_al_wvalid = v[0]; s1_al_wvalid = v[1]; m_al_wready = wr;
      s0_al_waddr = 10'($urandom); s1_al_waddr = 10'($urandom);
      s0_al_wdata = $urandom; s1_al_wdata = $urandom;
      #1;
      exp_wv = (owner >= 0) ? v[owner] : 1'b0;
      n_vec++;
      if ({m_al_wvalid, s0_al_wready, s1_al_wready} !==
          {exp_wv, owner == 0 && wr, owner == 1 && wr}) begin
        n_err++; $display("FAIL rwrite_k%0d_grant: got %b expected wv=%b owner=%0d", k,
                          {m_al_wvalid, s0_al_wready, s1_al_wready}, exp_wv, owner);
      end
      if (exp_wv) begin
        ea = (owner == 1) ? s1_al_waddr : s0_al_waddr;
        ed = (owner == 1) ? s1_al_wdata : s0_al_wdata;
        n_vec++;
        if ({m_al_waddr, m_al_wdata} !== {ea, ed}) begin
          n_err++; $display("FAIL rwrite_k%0d_payload: got %h/%h expected %h/%h", k,
                            m_al_waddr, m_al_wdata, ea, ed);
        end
      end
      if (owner < 0) begin
        if (v[0] && v[1]) owner = 1 - last;
        else if (v[0])    owner = 0;
        else if (v[1])    owner = 1;
      end else begin
        oth = 1 - owner;
        if (!v[owner]) begin
          last = owner; run = 0;
          owner = v[oth] ? oth : -1;
        end else if (wr) begin
          run++;
          if (run == MAX_HOLD) begin
            run = 0;
            if (v[oth]) begin last = owner; owner = oth; end
          end
        end
      end
    end
    clear_inputs();
  endtask

  task automatic test_interleaved_reads();
    apply_reset();
    m_al_arready = 1'b1; s0_al_rready = 1'b1; s1_al_rready = 1'b1;
    @(negedge clk);
    s0_al_arvalid = 1'b1; s0_al_araddr = 10'h020;
    s1_al_arvalid = 1'b1; s1_al_araddr = 10'h030;
    #1;
    n_vec++;
    if ({m_al_arvalid, s0_al_arready, s1_al_arready, m_al_araddr} !== {3'b110, 10'h020}) begin
      n_err++; $display("FAIL ileave_ar_first: got %b addr %h expected 110 addr 020",
                        {m_al_arvalid, s0_al_arready, s1_al_arready}, m_al_araddr);
    end
    @(negedge clk);
    s0_al_arvalid = 1'b0;
    #1;
    n_vec++;
    if ({m_al_arvalid, s0_al_arready, s1_al_arready, m_al_araddr} !== {3'b101, 10'h030}) begin
      n_err++; $display("FAIL ileave_ar_second: got %b addr %h expected 101 addr 030",
                        {m_al_arvalid, s0_al_arready, s1_al_arready}, m_al_araddr);
    end
    @(negedge clk);
    s1_al_arvalid = 1'b0; m_al_rvalid = 1'b1; m_al_rdata = 32'hA;
    #1;
    n_vec++;
    if ({s0_al_rvalid, s1_al_rvalid, m_al_rready, s0_al_rdata} !== {3'b101, 32'hA}) begin
      n_err++; $display("FAIL ileave_resp_a: got %b data %h expected 101 data a",
                        {s0_al_rvalid, s1_al_rvalid, m_al_rready}, s0_al_rdata);
    end
    @(negedge clk);
    m_al_rdata = 32'hB;
    #1;
    n_vec++;
    if ({s0_al_rvalid, s1_al_rvalid, m_al_rready, s1_al_rdata} !== {3'b011, 32'hB}) begin
      n_err++; $display("FAIL ileave_resp_b: got %b data %h expected 011 data b",
                        {s0_al_rvalid, s1_al_rvalid, m_al_rready}, s1_al_rdata);
    end
    @(negedge clk);
    m_al_rvalid = 1'b0;
    #1;
    n_vec++;
    if ({m_al_rready, rd_orphan} !== 2'b10) begin
      n_err++; $display("FAIL ileave_drained: got %b expected 10", {m_al_rready, rd_orphan});
    end
  endtask

  task automatic test_fifo_full();
    apply_reset();
    m_al_arready = 1'b1; s0_al_rready = 1'b1;
    for (int i = 0; i < DEPTH; i++) begin
      @(negedge clk);
      s0_al_arvalid = 1'b1; s0_al_araddr = 10'(64 + i);
      #1;
      n_vec++;
      if ({m_al_arvalid, s0_al_arready} !== 2'b11) begin
        n_err++; $display("FAIL full_accept%0d: got %b expected 11", i,
                          {m_al_arvalid, s0_al_arready});
      end
    end
    @(negedge clk);
    s0_al_araddr = 10'(64 + DEPTH);
    #1;
    n_vec++;
    if ({m_al_arvalid, s0_al_arready} !== 2'b00) begin
      n_err++; $display("FAIL full_block: got %b expected 00", {m_al_arvalid, s0_al_arready});
    end
    @(negedge clk);
    m_al_rvalid = 1'b1; m_al_rdata = $urandom;
    #1;
    n_vec++;
    if ({s0_al_rvalid, m_al_rready, m_al_arvalid, s0_al_arready, m_al_araddr} !==
        {4'b1111, 10'(64 + DEPTH)}) begin
      n_err++; $display("FAIL full_pop_push: got %b addr %h expected 1111 addr %h",
                        {s0_al_rvalid, m_al_rready, m_al_arvalid, s0_al_arready},
                        m_al_araddr, 10'(64 + DEPTH));
    end
    @(negedge clk);
    s0_al_arvalid = 1'b0;
    for (int i = 0; i < DEPTH; i++) begin
      m_al_rdata = $urandom;
      #1;
      n_vec++;
      if ({s0_al_rvalid, s1_al_rvalid, m_al_rready} !== 3'b101) begin
        n_err++; $display("FAIL full_drain%0d: got %b expected 101", i,
                          {s0_al_rvalid, s1_al_rvalid, m_al_rready});
      end
      @(negedge clk);
    end
    m_al_rvalid = 1'b0;
    #1;
    n_vec++;
    if ({m_al_rready, rd_orphan, m_al_arvalid} !== 3'b100) begin
      n_err++; $display("FAIL full_empty: got %b expected 100",
                        {m_al_rready, rd_orphan, m_al_arvalid});
    end
  endtask

  task automatic test_backpressure();
    apply_reset();
    @(negedge clk);
    s1_al_arvalid = 1'b1; s1_al_araddr = 10'h031;
    #1;
    n_vec++;
    if ({m_al_arvalid, s1_al_arready, m_al_araddr} !== {2'b10, 10'h031}) begin
      n_err++; $display("FAIL bp_ar_wait: got %b addr %h expected 10 addr 031",
                        {m_al_arvalid, s1_al_arready}, m_al_araddr);
    end
    @(negedge clk);
    s0_al_arvalid = 1'b1; s0_al_araddr = 10'h021;
    for (int i = 0; i < 2; i++) begin
      #1;
      n_vec++;
      if ({s0_al_arready, s1_al_arready, m_al_araddr} !== {2'b00, 10'h031}) begin
        n_err++; $display("FAIL bp_ar_stable%0d: got %b addr %h expected 00 addr 031", i,
                          {s0_al_arready, s1_al_arready}, m_al_araddr);
      end
      @(negedge clk);
    end
    m_al_arready = 1'b1;
    #1;
    n_vec++;
    if ({s0_al_arready, s1_al_arready, m_al_araddr} !== {2'b01, 10'h031}) begin
      n_err++; $display("FAIL bp_ar_hs1: got %b addr %h expected 01 addr 031",
                        {s0_al_arready, s1_al_arready}, m_al_araddr);
    end
    @(negedge clk);
    s1_al_arvalid = 1'b0;
    #1;
    n_vec++;
    if ({s0_al_arready, s1_al_arready, m_al_araddr} !== {2'b10, 10'h021}) begin
      n_err++; $display("FAIL bp_ar_hs0: got %b addr %h expected 10 addr 021",
                        {s0_al_arready, s1_al_arready}, m_al_araddr);
    end
    @(negedge clk);
    s0_al_arvalid = 1'b0; m_al_arready = 1'b0;
    m_al_rvalid = 1'b1; m_al_rdata = 32'h111; s0_al_rready = 1'b1; s1_al_rready = 1'b0;
    for (int i = 0; i < 2; i++) begin
      #1;
      n_vec++;
      if ({s0_al_rvalid, s1_al_rvalid, m_al_rready} !== 3'b010) begin
        n_err++; $display("FAIL bp_r_stall%0d: got %b expected 010", i,
                          {s0_al_rvalid, s1_al_rvalid, m_al_rready});
      end
      @(negedge clk);
    end
    s1_al_rready = 1'b1;
    #1;
    n_vec++;
    if ({s0_al_rvalid, s1_al_rvalid, m_al_rready, s1_al_rdata} !== {3'b011, 32'h111}) begin
      n_err++; $display("FAIL bp_r_release: got %b data %h expected 011 data 111",
                        {s0_al_rvalid, s1_al_rvalid, m_al_rready}, s1_al_rdata);
    end
    @(negedge clk);
    m_al_rdata = 32'h222;
    #1;
    n_vec++;
    if ({s0_al_rvalid, s1_al_rvalid, m_al_rready, s0_al_rdata} !== {3'b101, 32'h222}) begin
      n_err++; $display("FAIL bp_r_second: got %b data %h expected 101 data 222",
                        {s0_al_rvalid, s1_al_rvalid, m_al_rready}, s0_al_rdata);
    end
    @(negedge clk);
    m_al_rvalid = 1'b0;
  endtask

  task automatic test_orphan_reset();
    logic [9:0] obs;
    apply_reset();
    @(negedge clk);
    m_al_rvalid = 1'b1; m_al_rdata = $urandom;
    #1;
    n_vec++;
    if ({s0_al_rvalid, s1_al_rvalid, m_al_rready, rd_orphan} !== 4'b0010) begin
      n_err++; $display("FAIL orphan_accept: got %b expected 0010",
                        {s0_al_rvalid, s1_al_rvalid, m_al_rready, rd_orphan});
    end
    @(negedge clk);
    m_al_rvalid = 1'b0;
    #1;
    n_vec++;
    if (rd_orphan !== 1'b1) begin
      n_err++; $display("FAIL orphan_pulse: got %b expected 1", rd_orphan);
    end
    @(negedge clk); #1;
    n_vec++;
    if (rd_orphan !== 1'b0) begin
      n_err++; $display("FAIL orphan_pulse_end: got %b expected 0", rd_orphan);
    end
    m_al_wready = 1'b1; m_al_arready = 1'b1;
    @(negedge clk);
    s0_al_wvalid = 1'b1; s1_al_arvalid = 1'b1; s1_al_araddr = 10'h033;
    @(negedge clk);
    s1_al_arvalid = 1'b0;
    #1;
    n_vec++;
    if ({m_al_wvalid, s0_al_wready, m_al_rready} !== 3'b110) begin
      n_err++; $display("FAIL midburst_active: got %b expected 110",
                        {m_al_wvalid, s0_al_wready, m_al_rready});
    end
    #2;
    rst_n = 1'b0;
    #1;
    obs = {m_al_wvalid, s0_al_wready, s1_al_wready, m_al_arvalid, s0_al_arready,
           s1_al_arready, s0_al_rvalid, s1_al_rvalid, m_al_rready, rd_orphan};
    n_vec++;
    if (obs !== 10'b0000000010) begin
      n_err++; $display("FAIL midburst_async_reset: got %b expected 0000000010", obs);
    end
    @(negedge clk);
    rst_n = 1'b1; s0_al_wvalid = 1'b0; m_al_wready = 1'b0; m_al_arready = 1'b0;
    @(negedge clk);
    m_al_rvalid = 1'b1;
    #1;
    n_vec++;
    if ({s0_al_rvalid, s1_al_rvalid, m_al_rready} !== 3'b001) begin
      n_err++; $display("FAIL post_reset_resp: got %b expected 001",
                        {s0_al_rvalid, s1_al_rvalid, m_al_rready});
    end
    @(negedge clk);
    m_al_rvalid = 1'b0;
    #1;
    n_vec++;
    if (rd_orphan !== 1'b1) begin
      n_err++; $display("FAIL post_reset_orphan: got %b expected 1", rd_orphan);
    end
  endtask

  task automatic test_random_read();
    int q [$];
    int lock, arlast, sel, head;
    logic pend [2];
    logic [AW-1:0] paddr [2];
    logic empty, rr, pop, full, arv, exp_ar0, exp_ar1;
    apply_reset();
    lock = -1; arlast = 1;
    pend[0] = 1'b0; pend[1] = 1'b0; paddr[0] = '0; paddr[1] = '0;
    for (int k = 0; k < 300; k++) begin
      @(negedge clk);
      for (int m = 0; m < 2; m++) begin
        if (!pend[m] && $urandom_range(0, 2) == 0) begin
          pend[m] = 1'b1; paddr[m] = 10'($urandom);
        end
      end
      s0_al_arvalid = pend[0]; s0_al_araddr = paddr[0];
      s1_al_arvalid = pend[1]; s1_al_araddr = paddr[1];
      m_al_arready = ($urandom_range(0, 3) != 0);
      m_al_rvalid = (q.size() > 0) && ($urandom_range(0, 1) == 1);
      m_al_rdata = $urandom;
      s0_al_rready = ($urandom_range(0, 3) != 0);
      s1_al_rready = ($urandom_range(0, 3) != 0);
      #1;
      empty = (q.size() == 0);
      head = empty ? 0 : q[0];
      rr = (head == 1) ? s1_al_rready : s0_al_rready;
      pop = m_al_rvalid && !empty && rr;
      full = (q.size() == DEPTH) && !pop;
      arv = (pend[0] || pend[1]) && !full;
      if (lock >= 0)              sel = lock;
      else if (pend[0] && pend[1]) sel = 1 - arlast;
      else                        sel = pend[1] ? 1 : 0;
      exp_ar0 = arv && m_al_arready && sel == 0;
      exp_ar1 = arv && m_al_arready && sel == 1;
      n_vec++;
      if ({m_al_arvalid, s0_al_arready, s1_al_arready} !== {arv, exp_ar0, exp_ar1}) begin
        n_err++; $display("FAIL rread_k%0d_ar: got %b expected %b", k,
                          {m_al_arvalid, s0_al_arready, s1_al_arready}, {arv, exp_ar0, exp_ar1});
      end
      if (arv) begin
        n_vec++;
        if (m_al_araddr !== paddr[sel]) begin
          n_err++; $display("FAIL rread_k%0d_araddr: got %h expected %h", k,
                            m_al_araddr, paddr[sel]);
        end
      end
      n_vec++;
      if ({s0_al_rvalid, s1_al_rvalid, m_al_rready, rd_orphan} !==
          {m_al_rvalid && !empty && head == 0, m_al_rvalid && !empty && head == 1,
           empty || rr, 1'b0}) begin
        n_err++; $display("FAIL rread_k%0d_r: got %b head %0d empty %b", k,
                          {s0_al_rvalid, s1_al_rvalid, m_al_rready, rd_orphan}, head, empty);
      end
      if (m_al_rvalid && !empty) begin
        n_vec++;
        if (((head == 1) ? s1_al_rdata : s0_al_rdata) !== m_al_rdata) begin
          n_err++; $display("FAIL rread_k%0d_rdata: got %h expected %h", k,
                            (head == 1) ? s1_al_rdata : s0_al_rdata, m_al_rdata);
        end
      end
      if (pop) void'(q.pop_front());
      if (arv && m_al_arready) begin
        q.push_back(sel); arlast = sel; pend[sel] = 1'b0;
      end
      lock = (arv && !m_al_arready) ? sel : -1;
    end
    clear_inputs();
  endtask

  initial begin
    #500000;
    $display("FAIL watchdog: simulation exceeded time limit, got timeout expected finish");
    $fatal(1);
  end

  initial begin
    clear_inputs();
    test_reset();
    test_single_write();
    test_write_contention();
    test_random_write();
    test_interleaved_reads();
    test_fifo_full();
    test_backpressure();
    test_orphan_reset();
    test_random_read();
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
